// File: rtl/fpadd_pkg.sv
// Shared FP32 field definitions, operand classification and tag payload for fpadd_issue_ctrl.
// The tag carries bypass fields only when FPADD_SPECIAL_BYPASS_EN is defined.
package fpadd_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [FP_W-1:0]  QNAN    = 32'h7FC00000;

  typedef enum logic [1:0] {
    FP_NORMAL,
    FP_ZERO,
    FP_INF,
    FP_NAN
  } fp_class_e;

  // Subnormals (exp == 0) are classed as zero; the adder flushes them.
  function automatic fp_class_e fp_classify(input logic [FP_W-1:0] x);
    fp_class_e c;
    if (x[EXP_MSB:EXP_LSB] == EXP_MAX) begin
      c = (x[MANT_W-1:0] != '0) ? FP_NAN : FP_INF;
    end else if (x[EXP_MSB:EXP_LSB] == '0) begin
      c = FP_ZERO;
    end else begin
      c = FP_NORMAL;
    end
    return c;
  endfunction

`ifdef FPADD_SPECIAL_BYPASS_EN
  typedef struct packed {
    logic            valid;
    logic            bypass;
    logic [FP_W-1:0] value;
  } tag_t;
`else
  typedef struct packed {
    logic valid;
  } tag_t;
`endif

endpackage

// File: rtl/fpadd_result_fifo.sv
// Show-ahead result FIFO with occupancy count; head reads as zero while empty.
module fpadd_result_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head_data,
  output logic                           head_valid,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok_c;

  assign head_valid = (count != '0);
  assign pop_ok_c   = pop && head_valid;
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // Storage needs no reset: the head is masked while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop_ok_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpadd_issue_ctrl.sv
// Streaming front-end and in-order result collector for the fixed-latency FP32 adder.
// Special-operand bypass path is compiled in when FPADD_SPECIAL_BYPASS_EN is defined.
module fpadd_issue_ctrl
  import fpadd_pkg::*;
#(
  parameter int unsigned ADD_LAT   = 2,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_bypass
);

  localparam int unsigned STAGES = ADD_LAT + 1;
  localparam int unsigned CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int unsigned SUM_W  = $clog2(OUT_DEPTH + STAGES + 1);
`ifdef FPADD_SPECIAL_BYPASS_EN
  localparam int unsigned RES_W  = FP_W + 1;
`else
  localparam int unsigned RES_W  = FP_W;
`endif

  logic             accept_c;
  tag_t             new_tag_c;
  tag_t             tag_q [STAGES];
  logic [SUM_W-1:0] inflight_c;
  logic [CNT_W-1:0] fifo_count;
  logic [RES_W-1:0] fifo_wdata_c;
  logic [RES_W-1:0] fifo_head;

  assign accept_c = in_valid && in_ready;

`ifdef FPADD_SPECIAL_BYPASS_EN
  fp_class_e        ca_c;
  fp_class_e        cb_c;
  logic             byp_c;
  logic [FP_W-1:0]  byp_val_c;

  // Resolve operand pairs the adder cannot handle; priority NaN > inf > zero.
  always_comb begin
    ca_c      = fp_classify(in_a);
    cb_c      = fp_classify(in_b);
    byp_c     = 1'b1;
    byp_val_c = '0;
    if (ca_c == FP_NAN || cb_c == FP_NAN) begin
      byp_val_c = QNAN;
    end else if (ca_c == FP_INF && cb_c == FP_INF) begin
      byp_val_c = (in_a[SIGN_BIT] != in_b[SIGN_BIT]) ? QNAN : in_a;
    end else if (ca_c == FP_INF) begin
      byp_val_c = in_a;
    end else if (cb_c == FP_INF) begin
      byp_val_c = in_b;
    end else if (ca_c == FP_ZERO && cb_c == FP_ZERO) begin
      byp_val_c = {in_a[SIGN_BIT] & in_b[SIGN_BIT], 31'b0};
    end else if (ca_c == FP_ZERO) begin
      byp_val_c = in_b;
    end else if (cb_c == FP_ZERO) begin
      byp_val_c = in_a;
    end else begin
      byp_c = 1'b0;
    end
  end

  always_comb begin
    new_tag_c       = '0;
    new_tag_c.valid = accept_c;
    if (accept_c) begin
      new_tag_c.bypass = byp_c;
      new_tag_c.value  = byp_val_c;
    end
  end

  assign fifo_wdata_c = {tag_q[STAGES-1].bypass,
                         tag_q[STAGES-1].bypass ? tag_q[STAGES-1].value : add_out};
  assign res_data     = fifo_head[FP_W-1:0];
  assign res_bypass   = fifo_head[FP_W];
`else
  always_comb begin
    new_tag_c       = '0;
    new_tag_c.valid = accept_c;
  end

  assign fifo_wdata_c = add_out;
  assign res_data     = fifo_head;
  assign res_bypass   = 1'b0;
`endif

  // Adder operands load on every accept, bypass pairs included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_a <= '0;
      add_b <= '0;
    end else if (accept_c) begin
      add_a <= in_a;
      add_b <= in_b;
    end
  end

  // Tag pipe mirrors the adder latency and never stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= new_tag_c;
      for (int unsigned i = 1; i < STAGES; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Credit: every in-flight tag owns a FIFO slot, so a write can never be dropped.
  always_comb begin
    inflight_c = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      inflight_c = inflight_c + SUM_W'(tag_q[i].valid);
    end
  end

  assign in_ready = (inflight_c + SUM_W'(fifo_count)) < SUM_W'(OUT_DEPTH);

  fpadd_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (OUT_DEPTH)
  ) u_result_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (tag_q[STAGES-1].valid),
    .push_data  (fifo_wdata_c),
    .pop        (res_ready),
    .head_data  (fifo_head),
    .head_valid (res_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Scoreboard bench for fpadd_issue_ctrl with a table-driven model of the 2-edge adder.
module tb_fpadd_issue_ctrl;

`ifdef FPADD_SPECIAL_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_bypass;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] d;
    logic        b;
    int          t;
  } exp_t;
  exp_t sb[$];

  fpadd_issue_ctrl #(.ADD_LAT(2), .OUT_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_out    (add_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_bypass (res_bypass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed sums; special pairs return junk when the bypass should win.
  function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case ({a, b})
      {32'h3F800000, 32'h40000000}: r = 32'h40400000;
      {32'h00000000, 32'h40A00000}: r = BYP_EN ? 32'hBAD00001 : 32'h40A00000;
      {32'h7F800000, 32'hFF800000}: r = BYP_EN ? 32'hBAD00002 : 32'h7FC00000;
      {32'h7F800000, 32'h3F800000}: r = BYP_EN ? 32'hBAD00003 : 32'h7F800000;
      {32'h40400000, 32'hBF800000}: r = 32'h40000000;
      {32'h3F800000, 32'h3F800000}: r = 32'h40000000;
      {32'h40000000, 32'h40000000}: r = 32'h40800000;
      {32'h40800000, 32'h40800000}: r = 32'h41000000;
      {32'h3F000000, 32'h3F000000}: r = 32'h3F800000;
      {32'h3FC00000, 32'h3FC00000}: r = 32'h40400000;
      {32'h40000000, 32'h3F800000}: r = 32'h40400000;
      default:                      r = 32'hDEAD0000;
    endcase
    return r;
  endfunction

  // Adder: add_a/add_b are its input registers; out valid ADD_LAT edges later.
  logic [31:0] ar1;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ar1     <= 32'h0;
      add_out <= 32'h0;
    end else begin
      ar1     <= adder_model(add_a, add_b);
      add_out <= ar1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare each popped result against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got %h with no result outstanding", res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (res_data !== e.d || res_bypass !== e.b || (e.t >= 0 && cyc != e.t)) begin
          failures++;
          $display("FAIL result: got data=%h byp=%b cyc=%0d expected data=%h byp=%b cyc=%0d",
                   res_data, res_bypass, cyc, e.d, e.b, e.t);
        end
      end
    end
  end

  // Called at a negedge; offers a pair until accepted, then pushes its expectation.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                      input logic byp, input bit timed);
    exp_t e;
    int   n;
    n        = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stuck at 0 for pair %h %h", a, b);
    end else begin
      e.d = d;
      e.b = byp;
      e.t = timed ? cyc + 4 : -1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] bp_a [6];
  logic [31:0] bp_b [6];
  logic [31:0] bp_d [6];

  initial begin
    int idx;
    bp_a = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h3F000000, 32'h3FC00000, 32'h40000000};
    bp_b = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h3F000000, 32'h3FC00000, 32'h3F800000};
    bp_d = '{32'h40000000, 32'h40800000, 32'h41000000, 32'h3F800000, 32'h40400000, 32'h40400000};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_add_a", add_a, 32'h0);
    check("rst_add_b", add_b, 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_res_bypass", 32'(res_bypass), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single pairs: adder path, zero bypass, special values; all at fixed latency.
    send(32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b1);
    wait_drain("drain_normal");
    send(32'h00000000, 32'h40A00000, 32'h40A00000, BYP_EN, 1'b1);
    wait_drain("drain_zero");
    send(32'h7F800000, 32'hFF800000, 32'h7FC00000, BYP_EN, 1'b1);
    wait_drain("drain_inf_minus_inf");
    send(32'h7F800000, 32'h3F800000, 32'h7F800000, BYP_EN, 1'b1);
    wait_drain("drain_inf_plus_one");

    // Back-to-back mixed: results must come out on consecutive cycles.
    send(32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b1);
    send(32'h00000000, 32'h40A00000, 32'h40A00000, BYP_EN, 1'b1);
    send(32'h40400000, 32'hBF800000, 32'h40000000, 1'b0, 1'b1);
    wait_drain("drain_mixed");

    // Backpressure: offer six pairs with the consumer stalled.
    res_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_a     = bp_a[idx];
      in_b     = bp_b[idx];
      if (in_ready) begin
        exp_t e;
        e.d = bp_d[idx];
        e.b = 1'b0;
        e.t = -1;
        sb.push_back(e);
        idx++;
      end
      @(negedge clk);
      if (idx == 6) break;
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(idx), 32'd4);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_res_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    wait_drain("drain_backpressure");
    @(negedge clk);
    check("bp_in_ready_high", 32'(in_ready), 32'd1);
    send(bp_a[4], bp_b[4], bp_d[4], 1'b0, 1'b1);
    send(bp_a[5], bp_b[5], bp_d[5], 1'b0, 1'b1);
    wait_drain("drain_bp_tail");

    // Reset with two pairs in flight and one in the FIFO.
    res_ready = 1'b0;
    send(bp_a[0], bp_b[0], bp_d[0], 1'b0, 1'b0);
    send(bp_a[1], bp_b[1], bp_d[1], 1'b0, 1'b0);
    send(bp_a[2], bp_b[2], bp_d[2], 1'b0, 1'b0);
    @(negedge clk);
    check("pre_reset_res_valid", 32'(res_valid), 32'd1);
    reset = 1'b1;
    sb.delete();
    #1;
    check("mid_reset_res_valid", 32'(res_valid), 32'd0);
    check("mid_reset_res_data", res_data, 32'h0);
    @(negedge clk);
    reset     = 1'b0;
    res_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_res_valid", 32'(res_valid), 32'd0);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    send(32'h40000000, 32'h3F800000, 32'h40400000, 1'b0, 1'b1);
    wait_drain("drain_after_reset");

    repeat (4) @(negedge clk);
    check("final_res_valid", 32'(res_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
